axis_byte_serializer: RTL

Single-clock AXI-Stream width down-converter: accepts DataWidth-bit beats and emits them as a byte stream (8-bit AXIS), LSB byte first. Bytes whose tkeep bit is 0 are skipped, so the output carries only valid bytes. It sits between the AXIS CDC FIFO output (MAC clock domain) and the byte-wide Ethernet MAC TX path. tlast is moved onto the last valid byte of the frame.

---
 rtl/axis_byte_serializer_if.sv | 44 ++++
 rtl/axis_byte_serializer.sv | 94 +++++++++
 2 files changed

// File: rtl/axis_byte_serializer_if.sv
// Port bundle for axis_byte_serializer: wide AXIS beat in, byte-wide AXIS out, null-last flag.
// slave is the serializer's view, master is the view of whatever drives and sinks it.
interface axis_byte_serializer_if #(
  parameter int DataWidth = 64,
  parameter int IdWidth   = 5,
  parameter int DestWidth = 5
);
  logic [DataWidth-1:0]   s_tdata_i;
  logic [DataWidth/8-1:0] s_tstrb_i;
  logic [DataWidth/8-1:0] s_tkeep_i;
  logic                   s_tlast_i;
  logic [IdWidth-1:0]     s_tid_i;
  logic [DestWidth-1:0]   s_tdest_i;
  logic                   s_tuser_i;
  logic                   s_tvalid_i;
  logic                   s_tready_o;

  logic [7:0]             m_tdata_o;
  logic                   m_tstrb_o;
  logic                   m_tlast_o;
  logic [IdWidth-1:0]     m_tid_o;
  logic [DestWidth-1:0]   m_tdest_o;
  logic                   m_tuser_o;
  logic                   m_tvalid_o;
  logic                   m_tready_i;

  logic                   null_last_o;

  modport slave (
    input  s_tdata_i, s_tstrb_i, s_tkeep_i, s_tlast_i, s_tid_i, s_tdest_i, s_tuser_i, s_tvalid_i,
    output s_tready_o,
    output m_tdata_o, m_tstrb_o, m_tlast_o, m_tid_o, m_tdest_o, m_tuser_o, m_tvalid_o,
    input  m_tready_i,
    output null_last_o
  );

  modport master (
    output s_tdata_i, s_tstrb_i, s_tkeep_i, s_tlast_i, s_tid_i, s_tdest_i, s_tuser_i, s_tvalid_i,
    input  s_tready_o,
    input  m_tdata_o, m_tstrb_o, m_tlast_o, m_tid_o, m_tdest_o, m_tuser_o, m_tvalid_o,
    output m_tready_i,
    input  null_last_o
  );
endinterface

// File: rtl/axis_byte_serializer.sv
// AXIS DataWidth->8 down-converter, LSB byte first, tkeep=0 bytes skipped, first byte the cycle after accept.
// s_tready_o follows m_tready_i combinationally on the final byte (no bubble); m_tuser_o only with AXIS_BYTE_SERIALIZER_TUSER_EN.
module axis_byte_serializer #(
  parameter int DataWidth = 64,
  parameter int IdWidth   = 5,
  parameter int DestWidth = 5
) (
  input logic                    clk_i,
  input logic                    rst_i,
  axis_byte_serializer_if.slave  bus
);
  localparam int NumBytes = DataWidth / 8;
  localparam int IdxWidth = $clog2(NumBytes);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [NumBytes-1:0]  strb;
    logic                 last;
    logic [IdWidth-1:0]   id;
    logic [DestWidth-1:0] dest;
  } hold_t;

  hold_t               hold_q;
  logic [NumBytes-1:0] rem_q;
  logic [NumBytes-1:0] rem_clr;
  logic [IdxWidth-1:0] idx;
  logic                null_last_q;
  logic                busy;
  logic                single;
  logic                fire;
  logic                accept;

  assign busy   = |rem_q;
  assign single = busy && ((rem_q & (rem_q - NumBytes'(1))) == '0);

  // Lowest remaining byte goes out first, so holes in tkeep are skipped in order.
  always_comb begin
    idx = '0;
    for (int i = NumBytes - 1; i >= 0; i--) begin
      if (rem_q[i]) idx = IdxWidth'(i);
    end
  end

  assign rem_clr = rem_q & ~(NumBytes'(1) << idx);
  assign fire    = busy && bus.m_tready_i;
  assign accept  = bus.s_tvalid_i && bus.s_tready_o;

  assign bus.s_tready_o = !busy || (fire && single);

  // A new beat overrides the clear of a simultaneous final-byte fire.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q      <= '0;
      rem_q       <= '0;
      null_last_q <= 1'b0;
    end else begin
      null_last_q <= accept && (bus.s_tkeep_i == '0) && bus.s_tlast_i;
      if (accept) begin
        hold_q <= '{data: bus.s_tdata_i,
                    strb: bus.s_tstrb_i,
                    last: bus.s_tlast_i,
                    id:   bus.s_tid_i,
                    dest: bus.s_tdest_i};
        rem_q  <= bus.s_tkeep_i;
      end else if (fire) begin
        rem_q  <= rem_clr;
      end
    end
  end

`ifdef AXIS_BYTE_SERIALIZER_TUSER_EN
  logic user_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      user_q <= 1'b0;
    end else if (accept) begin
      user_q <= bus.s_tuser_i;
    end
  end

  assign bus.m_tuser_o = user_q;
`else
  assign bus.m_tuser_o = 1'b0;
`endif

  assign bus.m_tdata_o   = hold_q.data[{idx, 3'b000} +: 8];
  assign bus.m_tstrb_o   = hold_q.strb[idx];
  assign bus.m_tlast_o   = single && hold_q.last;
  assign bus.m_tid_o     = hold_q.id;
  assign bus.m_tdest_o   = hold_q.dest;
  assign bus.m_tvalid_o  = busy;
  assign bus.null_last_o = null_last_q;
endmodule
